// File: rtl/axil_rd_master.sv
// axil_rd_master: single-outstanding AXI4-Lite read master.
// A local request (req_valid/req_addr) is turned into one AR/R transaction and
// the returned data/response is presented on rsp_* until the consumer takes it.
// Optional DATA-state watchdog: define AXIL_RD_TIMEOUT_EN to compile in an 8-bit
// wait counter that ends a silent read with SLVERR after TIMEOUT_CYCLES.
module axil_rd_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_resp,
  output logic                  ARVALID,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARREADY,
  input  logic                  RVALID,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  output logic                  RREADY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state;

  // The wait counter is 8 bits wide, so the limit must fit and leave room for
  // at least one real DATA cycle before expiry.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("axil_rd_master: TIMEOUT_CYCLES must be in 2..255");
  end

`ifdef AXIL_RD_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  localparam logic [1:0] RESP_SLVERR   = 2'b10;

  logic [7:0] timeout_count;
  logic [7:0] timeout_next;

  assign timeout_next = timeout_count + 8'd1;
`endif

  // Transaction FSM; every handshake output is a register that flips together
  // with the state, so exactly one of req_ready/ARVALID/RREADY/rsp_valid is high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      rsp_valid <= 1'b0;
      ARADDR    <= '0;
      rsp_data  <= '0;
      rsp_resp  <= 2'b00;
`ifdef AXIL_RD_TIMEOUT_EN
      timeout_count <= 8'd0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            ARADDR    <= req_addr;
            req_ready <= 1'b0;
            ARVALID   <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= DATA;
`ifdef AXIL_RD_TIMEOUT_EN
            timeout_count <= 8'd0;
`endif
          end
        end
        DATA: begin
          if (RVALID) begin
            rsp_data  <= RDATA;
            rsp_resp  <= RRESP;
            RREADY    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`ifdef AXIL_RD_TIMEOUT_EN
          else if (timeout_next == TIMEOUT_LIMIT) begin
            timeout_count <= timeout_next;
            rsp_data      <= '0;
            rsp_resp      <= RESP_SLVERR;
            RREADY        <= 1'b0;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end else begin
            timeout_count <= timeout_next;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          ARVALID   <= 1'b0;
          RREADY    <= 1'b0;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axil_rd_master.md
AXIL_RD_MASTER -- requirements
Module: axil_rd_master

Interface
REQ-001 Parameter DATA_WIDTH, default 32, read data width.
REQ-002 Parameter ADDR_WIDTH, default 6, byte address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, maximum DATA-state wait; legal range 2..255.
REQ-004 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  local read request present.
REQ-007 req_ready  output  1  request accepted when high with req_valid.
REQ-008 req_addr  input  ADDR_WIDTH  local read address.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  local consumer accepts the response.
REQ-011 rsp_data  output  DATA_WIDTH  returned read data.
REQ-012 rsp_resp  output  2  returned AXI response code.
REQ-013 ARVALID  output  1  AXI4-Lite read address valid.
REQ-014 ARADDR  output  ADDR_WIDTH  AXI4-Lite read address.
REQ-015 ARREADY  input  1  slave accepts the address.
REQ-016 RVALID  input  1  slave read data valid.
REQ-017 RDATA  input  DATA_WIDTH  slave read data.
REQ-018 RRESP  input  2  slave read response.
REQ-019 RREADY  output  1  master accepts read data.

Function
REQ-020 The FSM SHALL have states IDLE, ADDR, DATA and RESP, and all outputs SHALL be registered or decoded from state only.
REQ-021 IDLE SHALL drive req_ready=1; on req_valid=1 it SHALL latch req_addr into ARADDR and go to ADDR.
REQ-022 ADDR SHALL drive ARVALID=1 and hold ARADDR stable; on ARREADY=1 it SHALL go to DATA, otherwise it SHALL stay in ADDR indefinitely.
REQ-023 DATA SHALL drive RREADY=1; on RVALID=1 it SHALL capture RDATA and RRESP into rsp_data and rsp_resp, then go to RESP.
REQ-024 DATA SHALL accept an RVALID that arrives in the first DATA cycle, which covers a slave asserting RVALID one cycle after the AR handshake.
REQ-025 An RVALID arriving outside DATA SHALL be ignored and SHALL NOT be captured.
REQ-026 RESP SHALL drive rsp_valid=1 with rsp_data and rsp_resp stable; on rsp_ready=1 it SHALL return to IDLE.
REQ-027 Minimum request-to-rsp_valid latency SHALL be 3 cycles (IDLE, ADDR, DATA), and back-to-back requests SHALL be separated by at least one IDLE cycle.
REQ-028 req_ready, ARVALID, RREADY and rsp_valid SHALL be mutually exclusive (one-hot with IDLE/ADDR/DATA/RESP).
REQ-029 rsp_data and rsp_resp SHALL hold their last captured value outside RESP.

Reset
REQ-030 RST=1 SHALL immediately force IDLE, req_ready=1, ARVALID=0, RREADY=0, rsp_valid=0, ARADDR=0, rsp_data=0, rsp_resp=2'b00, and timeout count=0.
REQ-031 A reset asserted in any state SHALL abandon the transaction with no response produced, and the first request after release SHALL be accepted normally.

Configuration
REQ-032 Macro AXIL_RD_TIMEOUT_EN SHALL compile in an 8-bit DATA-state wait counter.
REQ-033 With AXIL_RD_TIMEOUT_EN defined, the counter SHALL clear on entering DATA and increment each DATA cycle without RVALID.
REQ-034 With AXIL_RD_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES, the FSM SHALL go to RESP with rsp_resp=2'b10 (SLVERR) and rsp_data=0.
REQ-035 With AXIL_RD_TIMEOUT_EN defined, RVALID and timeout expiring in the same cycle SHALL resolve in favour of RVALID.
REQ-036 With AXIL_RD_TIMEOUT_EN undefined, no counter SHALL exist and DATA SHALL wait for RVALID indefinitely.

Verification
REQ-037 Bench SHALL cover the basic read: req_addr=6'h14, ARREADY tied 1, RVALID one cycle after the AR handshake with RDATA=32'hDEADBEEF and RRESP=0 -> rsp_valid on cycle 3 with rsp_data=32'hDEADBEEF and rsp_resp=0.
REQ-038 Bench SHALL cover address backpressure: ARREADY held low 5 cycles -> ARVALID=1 and ARADDR stable for all 5 cycles, with no RREADY.
REQ-039 Bench SHALL cover response backpressure: rsp_ready low 4 cycles in RESP -> rsp_valid and rsp_data held, req_ready=0 throughout.
REQ-040 Bench SHALL cover an error pass-through: RRESP=2'b10 with RDATA=32'h0 -> rsp_resp=2'b10.
REQ-041 Bench SHALL cover timeout with AXIL_RD_TIMEOUT_EN defined and TIMEOUT_CYCLES=16: RVALID never asserted -> rsp_valid after 16 DATA cycles with rsp_resp=2'b10 and rsp_data=0.
REQ-042 Bench SHALL cover reset mid-transaction: RST pulsed while in DATA -> all outputs at reset values within the same cycle, then a new req_addr=6'h04 completes normally.
